pc_fetch_ctrl: RTL and testbench

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

---
 rtl/pc_fetch_ctrl_if.sv | 43 ++++
 rtl/pc_fetch_ctrl.sv | 124 ++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_ctrl_if.sv
// rtl/pc_fetch_ctrl_if.sv - instruction memory and decoder handshake bundle for pc_fetch_ctrl
//
// Signals:
//   imem_req    fetch unit -> memory  request is active
//   imem_addr   fetch unit -> memory  word address, stable until imem_ack
//   imem_ack    memory -> fetch unit  request completes, imem_rdata valid
//   imem_rdata  memory -> fetch unit  fetched instruction word
//   instr_valid fetch unit -> decoder instr/instr_pc hold a fetched instruction
//   instr_ready decoder -> fetch unit accepts the instruction this cycle
//   instr       fetch unit -> decoder instruction word
//   instr_pc    fetch unit -> decoder address of instr
interface pc_fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - single-outstanding instruction fetch controller with redirect handling
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   redirect_valid jump / taken branch request this cycle
//   redirect_pc    jump / branch target (misaligned targets are replaced by EXC_PC)
//   exc_adel       one-cycle pulse after a misaligned redirect
//   bus            master side of pc_fetch_ctrl_if (imem request/ack, instr valid/ready)
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              exc_adel,
    pc_fetch_ctrl_if.master   bus
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] addr_q;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic        valid_q;
    logic        adel_q;

    logic        load_addr;
    logic        capture;
    logic        drop_valid;
    logic        misaligned;
    logic [31:0] target;

    assign misaligned = (redirect_pc[1:0] != 2'b00);
    assign target     = misaligned ? EXC_PC : redirect_pc;

    // A redirect always wins over the sequential next pc; only the REQ+ack
    // capture path advances pc from the completed address.
    always_comb begin
        state_n    = state;
        pc_n       = redirect_valid ? target : pc;
        load_addr  = 1'b0;
        capture    = 1'b0;
        drop_valid = 1'b0;
        case (state)
            BOOT: begin
                state_n   = REQ;
                load_addr = 1'b1;
            end
            REQ: begin
                if (redirect_valid) begin
                    if (bus.imem_ack) begin
                        // Data discarded; reissue immediately at the target.
                        load_addr = 1'b1;
                    end else begin
                        // Request still outstanding: wait for its ack, then drop it.
                        state_n = DROP;
                    end
                end else if (bus.imem_ack) begin
                    capture = 1'b1;
                    pc_n    = addr_q + 32'd4;
                    state_n = HOLD;
                end
            end
            DROP: begin
                if (bus.imem_ack) begin
                    state_n   = REQ;
                    load_addr = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid || bus.instr_ready) begin
                    drop_valid = 1'b1;
                    state_n    = REQ;
                    load_addr  = 1'b1;
                end
            end
            default: state_n = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            addr_q     <= RESET_PC;
            instr_q    <= 32'd0;
            instr_pc_q <= 32'd0;
            valid_q    <= 1'b0;
            adel_q     <= 1'b0;
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            adel_q <= redirect_valid & misaligned;
            if (load_addr) begin
                addr_q <= pc_n;
            end
            if (capture) begin
                instr_q    <= bus.imem_rdata;
                instr_pc_q <= addr_q;
                valid_q    <= 1'b1;
            end else if (drop_valid) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.imem_req    = (state == REQ) || (state == DROP);
    assign bus.imem_addr   = addr_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign exc_adel        = adel_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - scoreboard testbench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        exc_adel;

    pc_fetch_ctrl_if bus ();

    pc_fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .exc_adel       (exc_adel),
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_addr_q [$];
    logic [31:0] exp_ipc_q  [$];
    logic [31:0] exp_word_q [$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Request monitor: a new request starts when imem_req rises or stays high
    // after an ack; its address must match the scoreboard and stay stable.
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic [31:0] cur_addr = 32'd0;
    // Instruction monitor: every rise of instr_valid must match the next
    // expected instruction, which must then stay stable while valid.
    logic        prev_valid = 1'b0;
    logic [31:0] cur_ipc  = 32'd0;
    logic [31:0] cur_word = 32'd0;

    always @(negedge clk) begin
        if (!reset) begin
            prev_req   = 1'b0;
            prev_ack   = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (bus.imem_req && (!prev_req || prev_ack)) begin
                if (exp_addr_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_req: got %h expected none at %0t", bus.imem_addr, $time);
                end else begin
                    check32("req_addr", bus.imem_addr, exp_addr_q.pop_front());
                end
                cur_addr = bus.imem_addr;
            end else if (bus.imem_req) begin
                check32("addr_stable", bus.imem_addr, cur_addr);
            end
            prev_req = bus.imem_req;
            prev_ack = bus.imem_ack;

            if (bus.instr_valid && !prev_valid) begin
                if (exp_ipc_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_instr: got %h@%h expected none at %0t", bus.instr, bus.instr_pc, $time);
                end else begin
                    check32("instr_pc", bus.instr_pc, exp_ipc_q.pop_front());
                    check32("instr",    bus.instr,    exp_word_q.pop_front());
                end
                cur_ipc  = bus.instr_pc;
                cur_word = bus.instr;
            end else if (bus.instr_valid) begin
                check32("instr_pc_stable", bus.instr_pc, cur_ipc);
                check32("instr_stable",    bus.instr,    cur_word);
            end
            prev_valid = bus.instr_valid;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check32({tag, "_req"},   {31'd0, bus.imem_req},    32'd0);
        check32({tag, "_addr"},  bus.imem_addr,            32'h0000_3000);
        check32({tag, "_valid"}, {31'd0, bus.instr_valid}, 32'd0);
        check32({tag, "_instr"}, bus.instr,                32'd0);
        check32({tag, "_ipc"},   bus.instr_pc,             32'd0);
        check32({tag, "_adel"},  {31'd0, exc_adel},        32'd0);
    endtask

    initial begin
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'd0;
        bus.instr_ready = 1'b0;

        // Reset state, then release: one BOOT cycle with imem_req low.
        step();
        step();
        check_reset_outputs("rst");
        exp_addr_q.push_back(32'h0000_3000);
        reset = 1'b1;
        #2;
        check32("boot_req", {31'd0, bus.imem_req}, 32'd0);
        step();
        check32("req_after_boot", {31'd0, bus.imem_req}, 32'd1);

        // Fetch at 3000 with two wait cycles.
        step();
        step();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h2408_0001;
        exp_ipc_q.push_back(32'h0000_3000);
        exp_word_q.push_back(32'h2408_0001);
        step();
        bus.imem_ack = 1'b0;
        check32("hold_req", {31'd0, bus.imem_req}, 32'd0);
        exp_addr_q.push_back(32'h0000_3004);
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;

        // Redirect to 3010 while the 3004 request is outstanding: DROP, data discarded.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3010;
        step();
        redirect_valid = 1'b0;
        check32("drop_req", {31'd0, bus.imem_req}, 32'd1);
        step();
        exp_addr_q.push_back(32'h0000_3010);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        step();
        exp_ipc_q.push_back(32'h0000_3010);
        exp_word_q.push_back(32'h8C22_0010);
        bus.imem_rdata = 32'h8C22_0010;
        step();
        bus.imem_ack = 1'b0;

        // Decoder stalls for 5 cycles in HOLD.
        for (int i = 0; i < 5; i++) begin
            check32("stall_valid", {31'd0, bus.instr_valid}, 32'd1);
            check32("stall_req",   {31'd0, bus.imem_req},    32'd0);
            check32("stall_ipc",   bus.instr_pc,             32'h0000_3010);
            step();
        end
        exp_addr_q.push_back(32'h0000_3014);
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        check32("bubble_valid", {31'd0, bus.instr_valid}, 32'd0);
        exp_ipc_q.push_back(32'h0000_3014);
        exp_word_q.push_back(32'h0043_0820);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h0043_0820;
        step();
        bus.imem_ack = 1'b0;
        exp_addr_q.push_back(32'h0000_3018);
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;

        // Misaligned redirect to 3006 -> exc_adel pulse, refetch at EXC_PC.
        check32("adel_idle", {31'd0, exc_adel}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3006;
        step();
        redirect_valid = 1'b0;
        check32("adel_pulse", {31'd0, exc_adel}, 32'd1);
        step();
        check32("adel_clear", {31'd0, exc_adel}, 32'd0);
        exp_addr_q.push_back(32'h0000_4180);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h1111_1111;
        step();
        bus.imem_ack = 1'b0;

        // Redirect with ack in REQ: reissue at FFFF_FFFC, then wrap to 0.
        exp_addr_q.push_back(32'hFFFF_FFFC);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hBAD0_BAD0;
        step();
        redirect_valid = 1'b0;
        bus.imem_ack   = 1'b0;
        step();
        exp_ipc_q.push_back(32'hFFFF_FFFC);
        exp_word_q.push_back(32'hAC01_0000);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hAC01_0000;
        step();
        bus.imem_ack = 1'b0;
        exp_addr_q.push_back(32'h0000_0000);
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;

        // Reset during DROP; late ack during reset and BOOT is ignored.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3020;
        step();
        redirect_valid = 1'b0;
        check32("drop2_req", {31'd0, bus.imem_req}, 32'd1);
        reset = 1'b0;
        #1;
        check_reset_outputs("rst_drop");
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hFEED_FACE;
        step();
        step();
        exp_addr_q.push_back(32'h0000_3000);
        reset = 1'b1;
        step();
        bus.imem_ack = 1'b0;
        check32("restart_valid", {31'd0, bus.instr_valid}, 32'd0);
        check32("restart_addr",  bus.imem_addr,            32'h0000_3000);
        step();
        exp_ipc_q.push_back(32'h0000_3000);
        exp_word_q.push_back(32'h2409_0002);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h2409_0002;
        step();
        bus.imem_ack = 1'b0;
        exp_addr_q.push_back(32'h0000_3004);
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        step();

        check32("addr_q_drained",  exp_addr_q.size(), 32'd0);
        check32("instr_q_drained", exp_ipc_q.size(),  32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
